// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem read feeding a small output FIFO, with redirect flush.
// Define FETCH_SKID_EN for a 2-entry skid buffer; the default build uses a single entry.
module fetch_unit #(
    parameter int unsigned          REGI_SIZE = 16,
    parameter logic [REGI_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 imem_req_o,
    output logic [REGI_SIZE-1:0] imem_addr_o,
    input  logic                 imem_valid_i,
    input  logic [REGI_SIZE-1:0] imem_rdata_i,
    input  logic                 redirect_i,
    input  logic [REGI_SIZE-1:0] redirect_pc_i,
    input  logic                 stall_i,
    output logic                 valid_o,
    output logic [REGI_SIZE-1:0] next_pc_o,
    output logic [REGI_SIZE-1:0] instr_o
);

`ifdef FETCH_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_FULL
    } state_e;

    typedef struct packed {
        logic [REGI_SIZE-1:0] next_pc;
        logic [REGI_SIZE-1:0] instr;
    } entry_t;

    state_e               state_q, state_d;
    logic [REGI_SIZE-1:0] pc_q, pc_d;
    logic                 drop_q, drop_d;
    logic [1:0]           count_q, count_d;
    entry_t               buf_q [DEPTH];
    entry_t               buf_d [DEPTH];

    logic                 issue;
    logic                 resp;
    logic                 push;
    logic                 pop;
    logic [1:0]           cnt_mid;
    entry_t               new_entry;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        count_d   = count_q;
        buf_d     = buf_q;
        issue     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        cnt_mid   = count_q;
        resp      = (state_q == ST_WAIT) && imem_valid_i;
        // pc_q already points one past the outstanding fetch, which is exactly that entry's next_pc.
        new_entry = '{next_pc: pc_q, instr: imem_rdata_i};

        if (redirect_i) begin
            count_d = '0;
            pc_d    = redirect_pc_i;
            if ((state_q == ST_WAIT) && !imem_valid_i) begin
                state_d = ST_WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
                drop_d  = 1'b0;
            end
        end else begin
            pop     = (count_q != '0) && !stall_i;
            push    = resp && !drop_q;
            cnt_mid = count_q - 2'(pop);

            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    buf_d[i] = buf_q[i+1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (cnt_mid == 2'(i))) begin
                    buf_d[i] = new_entry;
                end
            end
            count_d = cnt_mid + 2'(push);

            case (state_q)
                ST_RUN: begin
                    if (count_q < DEPTH_C) begin
                        issue   = 1'b1;
                        pc_d    = pc_q + REGI_SIZE'(1);
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (resp) begin
                        drop_d  = 1'b0;
                        state_d = (count_d == DEPTH_C) ? ST_FULL : ST_RUN;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Outputs are forced idle while reset is held, even before the first reset edge.
    assign imem_req_o  = rst_i && issue;
    assign imem_addr_o = pc_q;
    assign valid_o     = rst_i && (count_q != '0);
    assign next_pc_o   = valid_o ? buf_q[0].next_pc : '0;
    assign instr_o     = valid_o ? buf_q[0].instr : '0;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            count_q <= count_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; count_q alone decides what is visible.
    always_ff @(posedge clk_i) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
// A second instance with RESET_PC=0xFFFF covers PC wrap out of reset.
module tb_fetch_unit;
    localparam int W = 16;
`ifdef FETCH_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic         rst_i = 1'b0, imem_valid_i = 1'b0, redirect_i = 1'b0, stall_i = 1'b0;
    logic [W-1:0] imem_rdata_i = '0, redirect_pc_i = '0;
    logic         imem_req_o, valid_o;
    logic [W-1:0] imem_addr_o, next_pc_o, instr_o;

    logic         b_rst = 1'b0, b_valid = 1'b0, b_redirect = 1'b0, b_stall = 1'b0;
    logic [W-1:0] b_rdata = '0, b_rpc = '0;
    logic         b_req, b_vo;
    logic [W-1:0] b_addr, b_npc, b_ins;

    fetch_unit #(.REGI_SIZE(W), .RESET_PC(16'h0000)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_valid_i(imem_valid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .stall_i(stall_i),
        .valid_o(valid_o), .next_pc_o(next_pc_o), .instr_o(instr_o)
    );

    fetch_unit #(.REGI_SIZE(W), .RESET_PC(16'hFFFF)) dut_b (
        .clk_i(clk_i), .rst_i(b_rst),
        .imem_req_o(b_req), .imem_addr_o(b_addr),
        .imem_valid_i(b_valid), .imem_rdata_i(b_rdata),
        .redirect_i(b_redirect), .redirect_pc_i(b_rpc), .stall_i(b_stall),
        .valid_o(b_vo), .next_pc_o(b_npc), .instr_o(b_ins)
    );

    typedef struct packed {
        logic [W-1:0] npc;
        logic [W-1:0] ins;
    } ent_t;

    typedef struct {
        int           due;
        logic [W-1:0] data;
    } resp_t;

    ent_t         m_q[$];
    logic [W-1:0] m_pc = '0, m_req_addr = '0;
    bit           m_out = 1'b0, m_drop = 1'b0;
    resp_t        due_q[$];
    int           cyc = 0, lat_lo = 1, lat_hi = 1;
    bit           spurious_en = 1'b0, data_fixed = 1'b1;
    logic [W-1:0] next_data = '0;
    int           checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the coming edge.
    task automatic model_step();
        bit    e_valid, e_req;
        ent_t  head, ent;
        resp_t rsp;
        e_valid = rst_i && (m_q.size() > 0);
        e_req   = rst_i && !redirect_i && !m_out && (m_q.size() < DEPTH);
        if (e_valid) head = m_q[0];
        else         head = '0;
        check("req", 32'(imem_req_o), 32'(e_req));
        if (e_req) check("addr", 32'(imem_addr_o), 32'(m_pc));
        check("valid", 32'(valid_o), 32'(e_valid));
        check("next_pc", 32'(next_pc_o), 32'(head.npc));
        check("instr", 32'(instr_o), 32'(head.ins));

        if (!rst_i) begin
            m_q.delete();
            m_pc   = 16'h0000;
            m_out  = 1'b0;
            m_drop = 1'b0;
        end else if (redirect_i) begin
            m_q.delete();
            m_pc = redirect_pc_i;
            if (m_out && !imem_valid_i) begin
                m_drop = 1'b1;
            end else begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
        end else begin
            if ((m_q.size() > 0) && !stall_i) void'(m_q.pop_front());
            if (e_req) begin
                m_req_addr = m_pc;
                m_pc       = m_pc + 16'd1;
                m_out      = 1'b1;
                rsp.due    = cyc + int'($urandom_range(lat_lo, lat_hi));
                rsp.data   = data_fixed ? next_data : 16'($urandom);
                due_q.push_back(rsp);
            end else if (m_out && imem_valid_i) begin
                m_out = 1'b0;
                if (m_drop) begin
                    m_drop = 1'b0;
                end else begin
                    ent.npc = m_req_addr + 16'd1;
                    ent.ins = imem_rdata_i;
                    m_q.push_back(ent);
                end
            end
        end
    endtask

    task automatic tick(input bit r, input bit rd, input logic [W-1:0] rpc, input bit st);
        bit           v;
        logic [W-1:0] d;
        @(posedge clk_i);
        #1;
        cyc++;
        v = 1'b0;
        d = 16'($urandom);
        for (int i = due_q.size() - 1; i >= 0; i--) begin
            if (due_q[i].due == cyc) begin
                v = 1'b1;
                d = due_q[i].data;
                due_q.delete(i);
            end
        end
        if (!v && spurious_en && !m_out && ($urandom_range(0, 15) == 0)) v = 1'b1;
        rst_i         = r;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        stall_i       = st;
        imem_valid_i  = v;
        imem_rdata_i  = d;
        #3;
        model_step();
    endtask

    task automatic find_req(output bit found);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1'b1, 1'b0, '0, 1'b0);
            found = imem_req_o;
        end
    endtask

    // First request address and first valid entry seen from the current cycle on.
    task automatic watch(input int max, output logic [W-1:0] a, output logic [W-1:0] n,
                         output logic [W-1:0] ins);
        bit ga, gn;
        ga = 1'b0;
        gn = 1'b0;
        a = '1;
        n = '1;
        ins = '1;
        for (int i = 0; i < max; i++) begin
            if (!ga && imem_req_o) begin
                ga = 1'b1;
                a  = imem_addr_o;
            end
            if (!gn && valid_o) begin
                gn  = 1'b1;
                n   = next_pc_o;
                ins = instr_o;
            end
            if (ga && gn) break;
            tick(1'b1, 1'b0, '0, 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] a, n, ins, rpc;
        int           reqs;
        bit           found, r, rd, st;

        repeat (3) tick(1'b0, 1'b0, '0, 1'b0);
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);

        // Reset release, single-cycle memory returning 0x1111.
        lat_lo = 1; lat_hi = 1; next_data = 16'h1111;
        tick(1'b1, 1'b0, '0, 1'b0);
        check("first_req", 32'(imem_req_o), 32'd1);
        check("first_addr", 32'(imem_addr_o), 32'h0000);
        next_data = 16'h2222;
        tick(1'b1, 1'b0, '0, 1'b1);
        tick(1'b1, 1'b0, '0, 1'b1);
        check("first_valid", 32'(valid_o), 32'd1);
        check("first_instr", 32'(instr_o), 32'h1111);
        check("first_npc", 32'(next_pc_o), 32'h0001);

        // Held stall: head stays put, only the skid slot may be filled.
        reqs = int'(imem_req_o);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, '0, 1'b1);
            reqs += int'(imem_req_o);
            check("stall_hold", 32'(instr_o), 32'h1111);
        end
        check("stall_reqs", 32'(reqs), 32'(DEPTH - 1));

        // Redirect while a request is outstanding.
        next_data = 16'h7777; lat_lo = 2; lat_hi = 2;
        find_req(found);
        check("redir_found", 32'(found), 32'd1);
        tick(1'b1, 1'b1, 16'h0040, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0);
        check("redir_bubble", 32'(valid_o), 32'd0);
        watch(20, a, n, ins);
        check("redir_addr", 32'(a), 32'h0040);
        check("redir_npc", 32'(n), 32'h0041);

        // Redirect coinciding with the response and a stall.
        lat_lo = 1; lat_hi = 1; next_data = 16'h5555;
        find_req(found);
        check("coinc_found", 32'(found), 32'd1);
        tick(1'b1, 1'b1, 16'h0100, 1'b1);
        tick(1'b1, 1'b0, '0, 1'b0);
        check("coinc_empty", 32'(valid_o), 32'd0);
        watch(20, a, n, ins);
        check("coinc_addr", 32'(a), 32'h0100);
        check("coinc_npc", 32'(n), 32'h0101);
        check("coinc_instr", 32'(ins), 32'h5555);

        // Reset during WAIT; the stale response lands in the first released cycle.
        lat_lo = 2; lat_hi = 2; next_data = 16'hBAD0;
        find_req(found);
        check("rstw_found", 32'(found), 32'd1);
        tick(1'b0, 1'b0, '0, 1'b0);
        next_data = 16'h3333;
        tick(1'b1, 1'b0, '0, 1'b0);
        watch(20, a, n, ins);
        check("rstw_addr", 32'(a), 32'h0000);
        check("rstw_npc", 32'(n), 32'h0001);
        check("rstw_instr", 32'(ins), 32'h3333);

        // Randomized traffic.
        lat_lo = 1; lat_hi = 3; data_fixed = 1'b0; spurious_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            st  = ($urandom_range(0, 9) < 3);
            tick(r, rd, rpc, st);
        end

        // RESET_PC = 0xFFFF instance: PC wraps to 0x0000.
        @(posedge clk_i); #1; b_rst = 1'b1; #3;
        check("b_first_req", 32'(b_req), 32'd1);
        check("b_first_addr", 32'(b_addr), 32'h0000FFFF);
        @(posedge clk_i); #1; b_valid = 1'b1; b_rdata = 16'h4444; #3;
        check("b_wait_noreq", 32'(b_req), 32'd0);
        @(posedge clk_i); #1; b_valid = 1'b0; #3;
        check("b_valid", 32'(b_vo), 32'd1);
        check("b_npc", 32'(b_npc), 32'h0000);
        check("b_instr", 32'(b_ins), 32'h4444);
        for (int i = 0; i < 5 && !b_req; i++) begin
            @(posedge clk_i);
            #4;
        end
        check("b_second_req", 32'(b_req), 32'd1);
        check("b_second_addr", 32'(b_addr), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter REGI_SIZE, default 16, giving the PC and instruction width.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the first fetch address after reset.
REQ-003 Port clk_i, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_i, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-005 Port imem_req_o, output, 1 bit: instruction-memory read request, one cycle per request.
REQ-006 Port imem_addr_o, output, REGI_SIZE bits: word address, valid while imem_req_o=1.
REQ-007 Port imem_valid_i, input, 1 bit: read response strobe for the single outstanding request.
REQ-008 Port imem_rdata_i, input, REGI_SIZE bits: instruction word, valid with imem_valid_i.
REQ-009 Port redirect_i, input, 1 bit: branch/jump taken, so fetch restarts at redirect_pc_i.
REQ-010 Port redirect_pc_i, input, REGI_SIZE bits: redirect target.
REQ-011 Port stall_i, input, 1 bit: downstream pipeline register not accepting this cycle.
REQ-012 Port valid_o, output, 1 bit: next_pc_o and instr_o carry a real instruction.
REQ-013 Port next_pc_o, output, REGI_SIZE bits: fetched PC + 1, modulo 2^REGI_SIZE.
REQ-014 Port instr_o, output, REGI_SIZE bits: fetched instruction word.

Function
REQ-015 The block SHALL use an FSM with states RUN (may issue), WAIT (one request outstanding) and FULL (buffer full, no issue).
REQ-016 In RUN with a free buffer slot, the block SHALL assert imem_req_o with imem_addr_o = fetch PC, increment the fetch PC by 1 (wrapping 0xFFFF to 0x0000), and enter WAIT.
REQ-017 At most one request SHALL be outstanding, so imem_req_o=0 in WAIT.
REQ-018 On imem_valid_i, the block SHALL push {pc+1, rdata} into the output buffer and go to RUN, or to FULL if the buffer is now full.
REQ-019 The buffer SHALL be a FIFO; valid_o=1 SHALL mean the buffer is non-empty, and next_pc_o/instr_o SHALL show the head entry.
REQ-020 When valid_o=0, next_pc_o and instr_o SHALL be 0, which is a bubble.
REQ-021 The head SHALL pop on a cycle with valid_o=1 and stall_i=0; with stall_i=1, outputs SHALL hold unchanged.
REQ-022 A push and a pop in the same cycle SHALL leave occupancy unchanged; FULL SHALL return to RUN on any pop.
REQ-023 Minimum latency SHALL be request at cycle N, response at N+1, valid_o=1 at N+2.
REQ-024 On redirect_i=1, the block SHALL flush the buffer, set fetch PC = redirect_pc_i, and drive valid_o=0 the next cycle.
REQ-025 A response to a request issued before the redirect SHALL be discarded using a drop flag, which clears on that response.
REQ-026 A redirect coinciding with imem_valid_i SHALL discard that response.
REQ-027 Redirect SHALL take priority over stall_i and over a pop in the same cycle.
REQ-028 A new request SHALL be issued no earlier than the cycle after a redirect, and only once no response is outstanding.
REQ-029 imem_valid_i arriving with no request outstanding SHALL be ignored.

Reset
REQ-030 While rst_i=0, the block SHALL set fetch PC=RESET_PC, state=RUN, buffer empty, drop flag=0, imem_req_o=0, valid_o=0, next_pc_o=0 and instr_o=0.
REQ-031 Reset mid-request SHALL abandon the outstanding request; its late response SHALL be ignored per REQ-029.
REQ-032 The first request SHALL issue in the first cycle with rst_i=1, at RESET_PC.

Configuration
REQ-033 Macro FETCH_SKID_EN defined: buffer depth SHALL be 2, so fetch continues for one entry while stalled.
REQ-034 Macro FETCH_SKID_EN undefined: buffer depth SHALL be 1, and no request SHALL issue while valid_o=1 and stall_i=1.

Verification
REQ-035 Reset release, memory returns 0x1111 one cycle later: imem_addr_o=0x0000, then valid_o=1 with instr_o=0x1111 and next_pc_o=0x0001.
REQ-036 stall_i held 5 cycles with FETCH_SKID_EN defined: at most 2 entries buffered, no request issued while FULL, and outputs stable.
REQ-037 redirect_i with target 0x0040 while WAIT: the old response is dropped, the next imem_addr_o is 0x0040, and the first valid_o shows next_pc_o=0x0041.
REQ-038 RESET_PC=0xFFFF: first next_pc_o=0x0000 and the second imem_addr_o=0x0000.
REQ-039 rst_i=0 mid-WAIT then released, stale imem_valid_i arrives: ignored, and a fetch at RESET_PC proceeds.
REQ-040 Redirect in the same cycle as imem_valid_i and stall_i=1: buffer is empty next cycle and valid_o=0.
